// File: rtl/srlatch_bank_ctrl.sv
// Sequencer for a bank of active-low set/reset latches. Converts single
// write / clear-all / set-all commands into timed, non-overlapping nset/nrst
// strobes, then reads q/nq back and reports a pass/fail response.
module srlatch_bank_ctrl #(
  parameter int N        = 8,
  parameter int PULSE_W  = 2,
  parameter int GAP      = 1,
  parameter int INIT_CLR = 1,
  localparam int IW      = $clog2((N < 2) ? 2 : N)
) (
  input  logic          ck,
  input  logic          nrst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [IW-1:0] req_idx,
  input  logic          req_val,
  output logic          resp_valid,
  output logic          resp_err,
  output logic          busy,
  output logic [N-1:0]  lat_nset,
  output logic [N-1:0]  lat_nrst,
  input  logic [N-1:0]  lat_q,
  input  logic [N-1:0]  lat_nq
);

  localparam int CMAX = (PULSE_W > GAP) ? PULSE_W : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PW_LAST  = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_CHECK, S_RESP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    op_r, op_n;
  logic [IW-1:0] idx_r, idx_n;
  logic          val_r, val_n;
  logic          bad_r, bad_n;   // op3 or out-of-range index: time it, drive nothing
  logic          init_r, init_n; // internal clear-all after reset, no response
  logic [N-1:0]  sel_n, sel_cur, set_low, rst_low;
  logic          err;

  // Next-state and command capture; phase lengths counted down in cnt
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_r;
    idx_n   = idx_r;
    val_n   = val_r;
    bad_n   = bad_r;
    init_n  = init_r;
    case (state)
      S_INIT: begin
        op_n    = 2'd1;
        idx_n   = '0;
        val_n   = 1'b0;
        bad_n   = 1'b0;
        init_n  = 1'b1;
        state_n = (GAP > 0) ? S_SETUP : S_PULSE;
        cnt_n   = (GAP > 0) ? GAP_LAST : PW_LAST;
      end
      S_IDLE: begin
        if (req_valid && req_ready) begin
          op_n    = req_op;
          idx_n   = req_idx;
          val_n   = req_val;
          bad_n   = (req_op == 2'd3) || (req_op == 2'd0 && int'(req_idx) >= N);
          init_n  = 1'b0;
          state_n = (GAP > 0) ? S_SETUP : S_PULSE;
          cnt_n   = (GAP > 0) ? GAP_LAST : PW_LAST;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_n = S_PULSE;
          cnt_n   = PW_LAST;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt == '0) begin
          if (GAP > 0) begin
            state_n = S_HOLD;
            cnt_n   = GAP_LAST;
          end else begin
            state_n = init_r ? S_IDLE : S_CHECK;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) state_n = init_r ? S_IDLE : S_CHECK;
        else           cnt_n   = cnt - 1'b1;
      end
      S_CHECK: state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Strobe masks for the coming cycle and readback error check in CHECK
  always_comb begin
    set_low = '0;
    rst_low = '0;
    sel_n   = '0;
    sel_cur = '0;
    for (int i = 0; i < N; i++) begin
      sel_n[i]   = (int'(idx_n) == i);
      sel_cur[i] = (int'(idx_r) == i);
    end
    // Only one of set/reset is ever selected per latch, so they cannot overlap
    if (state_n == S_PULSE && !bad_n) begin
      case (op_n)
        2'd0: if (val_n) set_low = sel_n; else rst_low = sel_n;
        2'd1: rst_low = '1;
        2'd2: set_low = '1;
        default: ;
      endcase
    end
    err = bad_r;
    case (op_r)
      2'd0: err = err | (|(sel_cur & (lat_q ^ {N{val_r}})))
                      | (|(sel_cur & (lat_nq ^ {N{~val_r}})));
      2'd1: err = err | (|lat_q) | ~(&lat_nq);
      2'd2: err = err | ~(&lat_q) | (|lat_nq);
      default: err = 1'b1;
    endcase
  end

  // State and registered outputs; the readback is captured at the CHECK edge
  always_ff @(posedge ck) begin
    if (!nrst) begin
      state      <= (INIT_CLR != 0) ? S_INIT : S_IDLE;
      cnt        <= '0;
      op_r       <= '0;
      idx_r      <= '0;
      val_r      <= 1'b0;
      bad_r      <= 1'b0;
      init_r     <= 1'b0;
      lat_nset   <= '1;
      lat_nrst   <= '1;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      op_r       <= op_n;
      idx_r      <= idx_n;
      val_r      <= val_n;
      bad_r      <= bad_n;
      init_r     <= init_n;
      lat_nset   <= ~set_low;
      lat_nrst   <= ~rst_low;
      req_ready  <= (state_n == S_IDLE);
      resp_valid <= (state_n == S_RESP);
      resp_err   <= (state_n == S_RESP) && err;
      busy       <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_srlatch_bank_ctrl.sv
// Bench for srlatch_bank_ctrl: N=8 and N=6 instances driving behavioural
// latch banks, reset/INIT vector table, command table, mid-op reset and
// random commands checked against a reference of the latch contents.
module tb_srlatch_bank_ctrl;
  localparam int PW = 2;

  logic       ck = 1'b0;
  logic       nrst = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = '0;
  logic [2:0] req_idx = '0;
  logic       req_val = 1'b0;
  logic       sel6 = 1'b0;
  logic [7:0] force_q = '0, flip_nq = '0;

  logic       ready8, rv8, re8, busy8, ready6, rv6, re6, busy6;
  logic [7:0] nset8, nrst8, q8, nq8;
  logic [5:0] nset6, nrst6, q6, nq6;
  logic [7:0] bank8 = 8'hA5;
  logic [5:0] bank6 = 6'h2A;
  logic       vin8, vin6, ready_m, resp_v_m, resp_e_m;
  logic [7:0] nset_m, nrst_m;

  int n_cmp = 0, n_bad = 0;
  int inv_bad = 0, resp_cnt8 = 0;
  logic [7:0] ref_q;

  always #5 ck = ~ck;

  assign vin8     = req_valid & ~sel6;
  assign vin6     = req_valid & sel6;
  assign ready_m  = sel6 ? ready6 : ready8;
  assign resp_v_m = sel6 ? rv6 : rv8;
  assign resp_e_m = sel6 ? re6 : re8;
  assign nset_m   = sel6 ? {2'b11, nset6} : nset8;
  assign nrst_m   = sel6 ? {2'b11, nrst6} : nrst8;
  assign q8       = bank8 | force_q;
  assign nq8      = ~(bank8 | force_q) ^ flip_nq;
  assign q6       = bank6;
  assign nq6      = ~bank6;

  srlatch_bank_ctrl #(.N(8), .PULSE_W(PW), .GAP(1), .INIT_CLR(1)) dut8 (
    .ck(ck), .nrst(nrst), .req_valid(vin8), .req_ready(ready8), .req_op(req_op),
    .req_idx(req_idx), .req_val(req_val), .resp_valid(rv8), .resp_err(re8),
    .busy(busy8), .lat_nset(nset8), .lat_nrst(nrst8), .lat_q(q8), .lat_nq(nq8));

  srlatch_bank_ctrl #(.N(6), .PULSE_W(PW), .GAP(1), .INIT_CLR(1)) dut6 (
    .ck(ck), .nrst(nrst), .req_valid(vin6), .req_ready(ready6), .req_op(req_op),
    .req_idx(req_idx), .req_val(req_val), .resp_valid(rv6), .resp_err(re6),
    .busy(busy6), .lat_nset(nset6), .lat_nrst(nrst6), .lat_q(q6), .lat_nq(nq6));

  // Latch banks respond to the strobes; invariant and response monitors
  always @(negedge ck) begin
    for (int i = 0; i < 8; i++) begin
      if (nset8[i] === 1'b0)      bank8[i] <= 1'b1;
      else if (nrst8[i] === 1'b0) bank8[i] <= 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      if (nset6[i] === 1'b0)      bank6[i] <= 1'b1;
      else if (nrst6[i] === 1'b0) bank6[i] <= 1'b0;
    end
    if ((|(~nset8 & ~nrst8)) === 1'b1 || (|(~nset6 & ~nrst6)) === 1'b1) inv_bad <= inv_bad + 1;
    if (rv8 === 1'b1) resp_cnt8 <= resp_cnt8 + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic       nrst;
    logic [7:0] nset, nrst_o;
    logic       ready, busy, resp;
  } rvec_t;

  typedef struct {
    logic       on6;
    logic [1:0] op;
    logic [2:0] idx;
    logic       val;
    logic [7:0] fq, fnq;
    logic       err;
    logic [7:0] smask, rmask;
    logic       b2b;
  } cmd_t;

  // Issue one command and check latency, error, strobe widths and handshake
  task automatic run_cmd(input string tag, input cmd_t c);
    int wait_c, lat, odd;
    int scnt[8], rcnt[8];
    logic rdy_low_ok, got_err;
    logic [15:0] got_m;
    sel6 = c.on6; force_q = c.fq; flip_nq = c.fnq;
    wait_c = 0;
    while (!ready_m && wait_c < 20) begin @(posedge ck); #1; wait_c++; end
    chk({tag, " ready"}, 32'(ready_m), 32'd1);
    if (c.b2b) chk({tag, " b2b accept"}, 32'(wait_c), 32'd0);
    req_op = c.op; req_idx = c.idx; req_val = c.val; req_valid = 1'b1;
    @(posedge ck); #1;
    req_valid = 1'b0;
    lat = -1; rdy_low_ok = 1'b1; got_err = 1'b0;
    for (int b = 0; b < 8; b++) begin scnt[b] = 0; rcnt[b] = 0; end
    for (int cyc = 0; cyc < 20 && lat < 0; cyc++) begin
      for (int b = 0; b < 8; b++) begin
        if (nset_m[b] == 1'b0) scnt[b]++;
        if (nrst_m[b] == 1'b0) rcnt[b]++;
      end
      if (ready_m) rdy_low_ok = 1'b0;
      if (resp_v_m) begin lat = cyc; got_err = resp_e_m; end
      else begin @(posedge ck); #1; end
    end
    odd = 0;
    for (int b = 0; b < 8; b++) begin
      got_m[b]     = (scnt[b] == PW);
      got_m[8 + b] = (rcnt[b] == PW);
      if (scnt[b] != 0 && scnt[b] != PW) odd++;
      if (rcnt[b] != 0 && rcnt[b] != PW) odd++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd5);
    chk({tag, " resp_err"}, 32'(got_err), 32'(c.err));
    chk({tag, " strobe mask"}, 32'(got_m), 32'({c.rmask, c.smask}));
    chk({tag, " strobe width"}, 32'(odd), 32'd0);
    chk({tag, " ready low while busy"}, 32'(rdy_low_ok), 32'd1);
    @(posedge ck); #1;
    chk({tag, " resp one cycle"}, 32'(resp_v_m), 32'd0);
    chk({tag, " ready after resp"}, 32'(ready_m), 32'd1);
    force_q = '0; flip_nq = '0;
  endtask

  rvec_t rv[8];
  cmd_t  ct[13];

  initial begin
    int    pulses, first_rdy, resp_before, k;
    cmd_t  c;
    logic [7:0] nxt, obs, nq;

    // Reset held two edges, then INIT clear-all: nrst low in cycles 1-2, ready at 4
    rv[0] = '{1'b0, 8'hff, 8'hff, 1'b0, 1'b1, 1'b0};
    rv[1] = '{1'b0, 8'hff, 8'hff, 1'b0, 1'b1, 1'b0};
    rv[2] = '{1'b1, 8'hff, 8'hff, 1'b0, 1'b1, 1'b0};
    rv[3] = '{1'b1, 8'hff, 8'h00, 1'b0, 1'b1, 1'b0};
    rv[4] = '{1'b1, 8'hff, 8'h00, 1'b0, 1'b1, 1'b0};
    rv[5] = '{1'b1, 8'hff, 8'hff, 1'b0, 1'b1, 1'b0};
    rv[6] = '{1'b1, 8'hff, 8'hff, 1'b1, 1'b0, 1'b0};
    rv[7] = '{1'b1, 8'hff, 8'hff, 1'b1, 1'b0, 1'b0};

    //         on6   op     idx   val   fq     fnq    err   smask  rmask  b2b
    ct[0]  = '{1'b0, 2'd0, 3'd3, 1'b1, 8'h00, 8'h00, 1'b0, 8'h08, 8'h00, 1'b0};
    ct[1]  = '{1'b0, 2'd0, 3'd5, 1'b0, 8'h20, 8'h00, 1'b1, 8'h00, 8'h20, 1'b1};
    ct[2]  = '{1'b0, 2'd0, 3'd7, 1'b1, 8'h00, 8'h00, 1'b0, 8'h80, 8'h00, 1'b1};
    ct[3]  = '{1'b0, 2'd1, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'hff, 1'b1};
    ct[4]  = '{1'b0, 2'd2, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hff, 8'h00, 1'b1};
    ct[5]  = '{1'b0, 2'd3, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1};
    ct[6]  = '{1'b0, 2'd1, 3'd0, 1'b0, 8'h04, 8'h00, 1'b1, 8'h00, 8'hff, 1'b1};
    ct[7]  = '{1'b0, 2'd0, 3'd2, 1'b1, 8'h04, 8'h00, 1'b0, 8'h04, 8'h00, 1'b1};
    ct[8]  = '{1'b0, 2'd0, 3'd2, 1'b1, 8'h00, 8'h04, 1'b1, 8'h04, 8'h00, 1'b1};
    ct[9]  = '{1'b0, 2'd2, 3'd0, 1'b0, 8'h00, 8'h01, 1'b1, 8'hff, 8'h00, 1'b1};
    ct[10] = '{1'b1, 2'd0, 3'd6, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
    ct[11] = '{1'b1, 2'd0, 3'd5, 1'b1, 8'h00, 8'h00, 1'b0, 8'h20, 8'h00, 1'b1};
    ct[12] = '{1'b1, 2'd3, 3'd1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1};

    for (int r = 0; r < 8; r++) begin
      nrst = rv[r].nrst;
      @(posedge ck); #1;
      chk($sformatf("rst%0d nset", r), 32'(nset8), 32'(rv[r].nset));
      chk($sformatf("rst%0d nrst", r), 32'(nrst8), 32'(rv[r].nrst_o));
      chk($sformatf("rst%0d ready", r), 32'(ready8), 32'(rv[r].ready));
      chk($sformatf("rst%0d busy", r), 32'(busy8), 32'(rv[r].busy));
      chk($sformatf("rst%0d resp", r), 32'({rv8, re8}), 32'({rv[r].resp, 1'b0}));
      chk($sformatf("rst%0d n6 strobes", r), 32'({nset6, nrst6}),
          32'({rv[r].nset[5:0], rv[r].nrst_o[5:0]}));
    end

    for (int i = 0; i < 13; i++) run_cmd($sformatf("cmd%0d", i), ct[i]);

    // Reset during the set-all pulse: strobes release at once, no response, INIT reruns
    sel6 = 1'b0;
    resp_before = resp_cnt8;
    req_op = 2'd2; req_idx = '0; req_val = 1'b0; req_valid = 1'b1;
    @(posedge ck); #1;
    req_valid = 1'b0;
    k = 0;
    while (nset8 != 8'h00 && k < 10) begin @(posedge ck); #1; k++; end
    chk("midrst in pulse", 32'(nset8), 32'h00);
    nrst = 1'b0;
    @(posedge ck); #1;
    chk("midrst strobes", 32'({nset8, nrst8}), 32'hffff);
    chk("midrst busy/ready", 32'({busy8, ready8, rv8}), 32'b100);
    nrst = 1'b1;
    pulses = 0; first_rdy = -1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge ck); #1;
      if (nrst8 == 8'h00) pulses++;
      if (ready8 && first_rdy < 0) first_rdy = cyc;
    end
    chk("midrst init pulses", 32'(pulses), 32'd2);
    chk("midrst ready cycle", 32'(first_rdy), 32'd4);
    chk("midrst no resp", 32'(resp_cnt8), 32'(resp_before));
    chk("midrst bank cleared", 32'(bank8), 32'h00);

    // Random commands against a model of the latch contents
    ref_q = 8'h00;
    for (int n = 0; n < 30; n++) begin
      c.on6 = 1'b0;
      c.op  = 2'($urandom_range(0, 3));
      c.idx = 3'($urandom_range(0, 7));
      c.val = 1'($urandom_range(0, 1));
      c.fq  = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      c.fnq = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      c.b2b = (n > 0);
      nxt = ref_q; c.smask = 8'h00; c.rmask = 8'h00;
      case (c.op)
        2'd0: begin
          nxt[c.idx] = c.val;
          if (c.val) c.smask = 8'(1 << c.idx); else c.rmask = 8'(1 << c.idx);
        end
        2'd1: begin nxt = 8'h00; c.rmask = 8'hff; end
        2'd2: begin nxt = 8'hff; c.smask = 8'hff; end
        default: ;
      endcase
      obs = nxt | c.fq;
      nq  = ~obs ^ c.fnq;
      c.err = (c.op == 2'd3)
           || (c.op == 2'd0 && (obs[c.idx] != c.val || nq[c.idx] != !c.val))
           || (c.op == 2'd1 && (obs != 8'h00 || nq != 8'hff))
           || (c.op == 2'd2 && (obs != 8'hff || nq != 8'h00));
      ref_q = nxt;
      run_cmd($sformatf("rnd%0d", n), c);
      chk($sformatf("rnd%0d bank", n), 32'(bank8), 32'(ref_q));
    end

    chk("no set/reset overlap", 32'(inv_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
